player_motion: RTL and testbench
================================

PLAYER_MOTION -- requirements
Module: player_motion

Interface
REQ-001 SHALL have parameter W, default 10, the width of the position coordinates.
REQ-002 SHALL have parameter TICK_DIV, default 500000, the number of clk cycles per movement tick (legal range >= 2).
REQ-003 SHALL have parameter MAX_STEP, default 4, the maximum step size in pixels per tick (legal range 1..15).
REQ-004 SHALL have parameters X_MIN 0, X_MAX 639, Y_MIN 0, Y_MAX 479, the inclusive position bounds.
REQ-005 SHALL have parameters START_X 10 and START_Y 10, the reset position (within bounds).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have ports ctrl_up, ctrl_down, ctrl_left, ctrl_right, input, 1 bit each: level key requests.
REQ-009 SHALL have ports player_x and player_y, output, W bits each: registered position.
REQ-010 SHALL have port speed, output, 4 bits: the step currently applied, 0 when idle.
REQ-011 SHALL have port moving, output, 1 bit: high while state is MOVE.
REQ-012 SHALL have port tick, output, 1 bit: one-cycle movement-tick strobe.

Function
REQ-013 SHALL run a tick counter 0..TICK_DIV-1; tick=1 when counter==TICK_DIV-1, and the counter then wraps to 0; period exactly TICK_DIV cycles.
REQ-014 SHALL sample the keys only in the tick cycle; key activity between ticks SHALL be ignored.
REQ-015 SHALL derive direction dx=right-left and dy=down-up (screen coordinates, up decreases y); opposing keys SHALL cancel to 0 on that axis.
REQ-016 SHALL implement FSM IDLE/MOVE. In IDLE on tick with a non-zero direction: go to MOVE, speed=1, and apply step 1.
REQ-017 In MOVE on tick with a direction equal to the previous tick's direction: speed=min(speed+1,MAX_STEP), and apply the new speed.
REQ-018 In MOVE on tick with a different non-zero direction: speed=1, apply step 1, and store the new direction.
REQ-019 On tick with a zero direction: go to IDLE, speed=0, and leave the position unchanged.
REQ-020 SHALL apply the step on both axes independently (a diagonal moves speed pixels on each axis).
REQ-021 SHALL compute each new coordinate in W+2-bit signed arithmetic, then clamp it to [MIN,MAX]; no wrap-around.
REQ-022 SHALL keep the FSM and speed behaviour unchanged when clamped; at an edge, the position stays at MIN/MAX while the key is held.
REQ-023 SHALL update player_x, player_y, speed and moving on the same edge that samples tick, so they are visible the cycle after tick=1.
REQ-024 SHALL not change any output in non-tick cycles.

Reset
REQ-025 With reset=1 at a clk edge: counter=0, player_x=START_X, player_y=START_Y, speed=0, moving=0, tick=0, state IDLE, and stored direction=0.
REQ-026 Reset SHALL take priority over a coincident tick and over all key inputs, including in the middle of a movement.
REQ-027 After reset deasserts, the first tick SHALL occur exactly TICK_DIV cycles after the last reset cycle.

Verification (TICK_DIV=4, defaults otherwise)
REQ-028 Release reset, no keys -> tick every 4 cycles; position stays (10,10); speed=0; moving=0.
REQ-029 Hold ctrl_right for 6 ticks -> speed 1,2,3,4,4,4; player_x 11,13,16,20,24,28; player_y=10.
REQ-030 Hold ctrl_up+ctrl_left from (10,10) -> steps 1,2,3,4 -> positions (9,9),(7,7),(4,4),(0,0); further ticks hold at (0,0) with speed=4.
REQ-031 Hold ctrl_left+ctrl_right -> dx=0, IDLE, no motion; then switch from right (speed 3) to down -> speed=1, y+1.
REQ-032 Assert reset while moving at speed 4 coincident with tick -> next cycle (10,10), speed 0, moving 0; first tick after 4 cycles.
REQ-033 Pulse ctrl_down for 2 cycles between ticks -> no position change.

Source files
------------

// File: rtl/player_motion.sv
// player_motion: keyboard-driven sprite position with tick-paced acceleration.
// Keys are sampled only on the movement tick. Holding the same direction
// ramps the step size up to MAX_STEP. Changing direction restarts the step
// at 1. The position is clamped to the configured bounds.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no direction on the last tick, speed 0
// MOVE  | direction held, speed ramps toward MAX_STEP
module player_motion #(
    parameter int W        = 10,
    parameter int TICK_DIV = 500000,
    parameter int MAX_STEP = 4,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 639,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 479,
    parameter int START_X  = 10,
    parameter int START_Y  = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ctrl_up,
    input  logic         ctrl_down,
    input  logic         ctrl_left,
    input  logic         ctrl_right,
    output logic [W-1:0] player_x,
    output logic [W-1:0] player_y,
    output logic [3:0]   speed,
    output logic         moving,
    output logic         tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]       TC     = CW'(TICK_DIV - 1);
    localparam logic [3:0]          MAX_S  = 4'(MAX_STEP);
    localparam logic signed [W+1:0] XMIN_S = (W+2)'(X_MIN);
    localparam logic signed [W+1:0] XMAX_S = (W+2)'(X_MAX);
    localparam logic signed [W+1:0] YMIN_S = (W+2)'(Y_MIN);
    localparam logic signed [W+1:0] YMAX_S = (W+2)'(Y_MAX);

    typedef enum logic {IDLE, MOVE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  x_q, y_q, x_d, y_d;
    logic [3:0]    speed_q, speed_d;
    logic [3:0]    dir_q, dir_d;
    logic [1:0]    dx, dy;

    logic signed [W+1:0] spd_s, step_x, step_y, nx, ny;

    assign tick     = (cnt_q == TC);
    assign player_x = x_q;
    assign player_y = y_q;
    assign speed    = speed_q;
    assign moving   = (state_q == MOVE);

    // Two-bit signed axis directions: 01 = +1, 11 = -1, opposing keys give 00.
    assign dx    = {ctrl_left & ~ctrl_right, ctrl_left ^ ctrl_right};
    assign dy    = {ctrl_up & ~ctrl_down, ctrl_up ^ ctrl_down};
    assign dir_d = {dx, dy};

    // Next FSM state and step size for the current key sample.
    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        if (dir_d == 4'b0000) begin
            state_d = IDLE;
            speed_d = 4'd0;
        end else if (state_q == MOVE && dir_d == dir_q) begin
            state_d = MOVE;
            speed_d = (speed_q >= MAX_S) ? MAX_S : speed_q + 4'd1;
        end else begin
            state_d = MOVE;
            speed_d = 4'd1;
        end
    end

    // Candidate coordinates in widened signed arithmetic, then clamped to bounds.
    always_comb begin
        spd_s  = $signed({{(W-2){1'b0}}, speed_d});
        step_x = (dx == 2'b01) ? spd_s : (dx == 2'b11) ? -spd_s : '0;
        step_y = (dy == 2'b01) ? spd_s : (dy == 2'b11) ? -spd_s : '0;
        nx     = $signed({2'b00, x_q}) + step_x;
        ny     = $signed({2'b00, y_q}) + step_y;
        if (nx < XMIN_S)      nx = XMIN_S;
        else if (nx > XMAX_S) nx = XMAX_S;
        if (ny < YMIN_S)      ny = YMIN_S;
        else if (ny > YMAX_S) ny = YMAX_S;
        x_d = nx[W-1:0];
        y_d = ny[W-1:0];
    end

    // Free-running tick divider; restarts from zero on reset.
    always_ff @(posedge clk) begin
        if (reset)     cnt_q <= '0;
        else if (tick) cnt_q <= '0;
        else           cnt_q <= cnt_q + CW'(1);
    end

    // FSM, speed and position: change only on the tick edge; reset wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            speed_q <= 4'd0;
            dir_q   <= 4'd0;
            x_q     <= W'(START_X);
            y_q     <= W'(START_Y);
        end else if (tick) begin
            state_q <= state_d;
            speed_q <= speed_d;
            dir_q   <= dir_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion with TICK_DIV=4; expected positions are
// queued when the tick samples the keys and checked after the update edge.
module tb_player_motion;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         ctrl_up = 1'b0, ctrl_down = 1'b0, ctrl_left = 1'b0, ctrl_right = 1'b0;
    logic [W-1:0] player_x, player_y;
    logic [3:0]   speed;
    logic         moving, tick;

    typedef struct {
        int    x;
        int    y;
        int    s;
        int    m;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    player_motion #(.W(W), .TICK_DIV(4)) dut (
        .clk(clk), .reset(reset),
        .ctrl_up(ctrl_up), .ctrl_down(ctrl_down),
        .ctrl_left(ctrl_left), .ctrl_right(ctrl_right),
        .player_x(player_x), .player_y(player_y),
        .speed(speed), .moving(moving), .tick(tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input int ex, input int ey, input int es, input int em);
        check({tag, " x"}, 32'(player_x), ex);
        check({tag, " y"}, 32'(player_y), ey);
        check({tag, " speed"}, 32'(speed), es);
        check({tag, " moving"}, 32'(moving), em);
    endtask

    task automatic set_keys(input logic [3:0] k);
        {ctrl_up, ctrl_down, ctrl_left, ctrl_right} = k;
    endtask

    // Returns the number of rising edges waited until tick is seen (bounded).
    task automatic wait_tick(output int n);
        n = 0;
        while (tick !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic apply(input logic [3:0] k, input int ex, input int ey, input int es,
                         input int em, input string tag);
        int   n;
        exp_t e;
        set_keys(k);
        wait_tick(n);
        if (tick !== 1'b1) check({tag, " tick seen"}, 32'(tick), 1);
        sb.push_back('{ex, ey, es, em, tag});
        @(posedge clk); #1;
        e = sb.pop_front();
        check_state(e.tag, e.x, e.y, e.s, e.m);
    endtask

    task automatic do_reset();
        set_keys(4'b0000);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    localparam logic [3:0] K_NONE = 4'b0000;
    localparam logic [3:0] K_R    = 4'b0001;
    localparam logic [3:0] K_L    = 4'b0010;
    localparam logic [3:0] K_D    = 4'b0100;
    localparam logic [3:0] K_UL   = 4'b1010;
    localparam logic [3:0] K_LR   = 4'b0011;

    initial begin
        int n;
        int ex, es;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 10, 10, 0, 0);
        check("reset tick", 32'(tick), 0);
        reset = 1'b0;

        // First tick after reset, then period
        wait_tick(n);
        check("first tick latency", n, 3);
        @(posedge clk); #1;
        check("tick one cycle", 32'(tick), 0);
        wait_tick(n);
        check("tick period", n, 3);
        @(posedge clk); #1;

        // Idle, no keys
        apply(K_NONE, 10, 10, 0, 0, "idle1");
        apply(K_NONE, 10, 10, 0, 0, "idle2");

        // Hold right: acceleration then saturation at MAX_STEP
        apply(K_R, 11, 10, 1, 1, "right1");
        apply(K_R, 13, 10, 2, 1, "right2");
        apply(K_R, 16, 10, 3, 1, "right3");
        apply(K_R, 20, 10, 4, 1, "right4");
        apply(K_R, 24, 10, 4, 1, "right5");
        apply(K_R, 28, 10, 4, 1, "right6");
        apply(K_NONE, 28, 10, 0, 0, "release");

        // Diagonal up-left into the minimum corner
        do_reset();
        apply(K_UL, 9, 9, 1, 1, "ul1");
        apply(K_UL, 7, 7, 2, 1, "ul2");
        apply(K_UL, 4, 4, 3, 1, "ul3");
        apply(K_UL, 0, 0, 4, 1, "ul4");
        apply(K_UL, 0, 0, 4, 1, "ul5");
        apply(K_UL, 0, 0, 4, 1, "ul6");

        // Opposing keys cancel; direction change restarts speed
        do_reset();
        apply(K_LR, 10, 10, 0, 0, "lr cancel");
        apply(K_R, 11, 10, 1, 1, "r1");
        apply(K_R, 13, 10, 2, 1, "r2");
        apply(K_R, 16, 10, 3, 1, "r3");
        apply(K_D, 16, 11, 1, 1, "turn down");
        apply(K_D, 16, 13, 2, 1, "down2");
        apply(K_NONE, 16, 13, 0, 0, "stop");

        // Short key pulse between ticks is ignored
        set_keys(K_D);
        @(posedge clk); #1;
        check_state("pulse mid1", 16, 13, 0, 0);
        @(posedge clk); #1;
        check_state("pulse mid2", 16, 13, 0, 0);
        set_keys(K_NONE);
        apply(K_NONE, 16, 13, 0, 0, "after pulse");

        // Reset coincident with tick while at full speed
        do_reset();
        apply(K_R, 11, 10, 1, 1, "pre1");
        apply(K_R, 13, 10, 2, 1, "pre2");
        apply(K_R, 16, 10, 3, 1, "pre3");
        apply(K_R, 20, 10, 4, 1, "pre4");
        wait_tick(n);
        check("tick before reset", 32'(tick), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_state("reset on tick", 10, 10, 0, 0);
        check("reset on tick tick", 32'(tick), 0);
        set_keys(K_NONE);
        wait_tick(n);
        check("tick after mid reset", n, 3);
        @(posedge clk); #1;
        check_state("after mid reset", 10, 10, 0, 0);

        // Run right into the maximum x bound
        ex = 10;
        es = 0;
        for (int i = 0; i < 160; i++) begin
            es = (es >= 4) ? 4 : es + 1;
            ex = (ex + es > 639) ? 639 : ex + es;
            apply(K_R, ex, 10, es, 1, "run right");
        end
        check("x at max", 32'(player_x), 639);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
